// File: rtl/decode_pixel_packer.sv
// Packs raster-order pixels from the decode normalizer into memory words,
// tagging row/frame ends and counting completed frames.
module decode_pixel_packer #(
  parameter int PIXEL_BIT  = 8,
  parameter int WORD_BIT   = 32,
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [PIXEL_BIT-1:0] dn_veri_i,
  input  logic                 dn_gecerli_i,
  output logic                 dn_hazir_o,
  output logic [WORD_BIT-1:0]  word_veri_o,
  output logic                 word_gecerli_o,
  output logic                 word_satir_son_o,
  output logic                 word_son_o,
  input  logic                 word_hazir_i,
  output logic [15:0]          frame_ctr_o
);

  localparam int PPW = WORD_BIT / PIXEL_BIT;
  localparam int FW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int CW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [FW-1:0] FILL_LAST = FW'(PPW - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);

  logic [FW-1:0]       fill_q;
  logic [CW-1:0]       col_q;
  logic [RW-1:0]       row_q;
  logic [WORD_BIT-1:0] pack_q;
  logic [WORD_BIT-1:0] word_d;

  logic last_fill;
  logic col_last;
  logic row_last;
  logic px_hs;
  logic complete;
  logic wd_hs;

  assign last_fill = (fill_q == FILL_LAST);
  assign col_last  = (col_q == COL_LAST);
  assign row_last  = (row_q == ROW_LAST);

  // Only the word-completing pixel can stall; nothing is taken in reset.
  assign dn_hazir_o = rstn_i &&
    (!last_fill || !word_gecerli_o || word_hazir_i);

  assign px_hs    = dn_gecerli_i && dn_hazir_o;
  assign complete = px_hs && last_fill;
  assign wd_hs    = word_gecerli_o && word_hazir_i;

  // Current pack contents with the incoming pixel dropped into its slice.
  always_comb begin
    word_d = pack_q;
    for (int i = 0; i < PPW; i++) begin
      if (fill_q == FW'(i)) begin
        word_d[i*PIXEL_BIT +: PIXEL_BIT] = dn_veri_i;
      end
    end
  end

  // Pack register and fill counter advance only on a pixel handshake.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pack_q <= '0;
      fill_q <= '0;
    end else if (px_hs) begin
      pack_q <= word_d;
      fill_q <= last_fill ? '0 : fill_q + 1'b1;
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (px_hs) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Output word register: reload on completion, else drop after handshake.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      word_veri_o      <= '0;
      word_gecerli_o   <= 1'b0;
      word_satir_son_o <= 1'b0;
      word_son_o       <= 1'b0;
    end else if (complete) begin
      word_veri_o      <= word_d;
      word_gecerli_o   <= 1'b1;
      word_satir_son_o <= col_last;
      word_son_o       <= col_last && row_last;
    end else if (wd_hs) begin
      word_gecerli_o   <= 1'b0;
    end
  end

  // Frame counter steps when the frame's last word is taken.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      frame_ctr_o <= '0;
    end else if (wd_hs && word_son_o) begin
      frame_ctr_o <= frame_ctr_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_decode_pixel_packer.sv
// Scoreboard bench for decode_pixel_packer on an 8x2 frame:
// driver queues expected words, monitor checks each presented word.
module tb_decode_pixel_packer;

  localparam int W = 8;
  localparam int H = 2;

  typedef struct packed {
    logic [31:0] w;
    logic        s;
    logic        l;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic [7:0]  dn_veri;
  logic        dn_gecerli;
  logic        dn_hazir;
  logic [31:0] word_veri;
  logic        word_gecerli;
  logic        word_satir_son;
  logic        word_son;
  logic        word_hazir;
  logic [15:0] frame_ctr;

  decode_pixel_packer #(
    .PIXEL_BIT (8),
    .WORD_BIT  (32),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .dn_veri_i       (dn_veri),
    .dn_gecerli_i    (dn_gecerli),
    .dn_hazir_o      (dn_hazir),
    .word_veri_o     (word_veri),
    .word_gecerli_o  (word_gecerli),
    .word_satir_son_o(word_satir_son),
    .word_son_o      (word_son),
    .word_hazir_i    (word_hazir),
    .frame_ctr_o     (frame_ctr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  exp_t exp_q[$];
  int   hs_cyc[$];
  int   exp_frames = 0;
  int   satir_cnt  = 0;
  int   son_cnt    = 0;

  int          m_fill = 0;
  int          m_col  = 0;
  int          m_row  = 0;
  logic [31:0] m_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_fill = 0;
    m_col = 0;
    m_row = 0;
    m_word = '0;
    exp_frames = 0;
  endtask

  task automatic model_accept(input logic [7:0] px);
    exp_t e;
    m_word[m_fill*8 +: 8] = px;
    if (m_fill == 3) begin
      e.w = m_word;
      e.s = (m_col == W - 1);
      e.l = (m_col == W - 1) && (m_row == H - 1);
      exp_q.push_back(e);
      m_fill = 0;
    end else begin
      m_fill++;
    end
    if (m_col == W - 1) begin
      m_col = 0;
      m_row = (m_row == H - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [7:0] px, output int stalls);
    bit ok;
    ok = 0;
    stalls = 0;
    dn_gecerli = 1'b1;
    dn_veri = px;
    for (int n = 0; n < 50; n++) begin
      #3;
      if (dn_hazir) begin
        ok = 1;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: pixel %h never accepted", px);
    end
    @(negedge clk);
    if (ok) model_accept(px);
  endtask

  task automatic send_seq(input logic [7:0] start, input logic [7:0] step,
                          input int n, output int stall_sum);
    int st;
    logic [7:0] px;
    stall_sum = 0;
    px = start;
    for (int i = 0; i < n; i++) begin
      send(px, st);
      stall_sum += st;
      px = px + step;
    end
    dn_gecerli = 1'b0;
    dn_veri = '0;
  endtask

  // Called at a falling edge; asserts reset mid-cycle.
  task automatic do_reset();
    #4;
    rstn = 1'b0;
    #1;
    chk("rst_word_gecerli", {31'd0, word_gecerli}, 32'd0);
    chk("rst_word_veri", word_veri, 32'd0);
    chk("rst_satir_son", {31'd0, word_satir_son}, 32'd0);
    chk("rst_son", {31'd0, word_son}, 32'd0);
    chk("rst_frame_ctr", {16'd0, frame_ctr}, 32'd0);
    chk("rst_dn_hazir", {31'd0, dn_hazir}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #3;
    chk("rel_dn_hazir", {31'd0, dn_hazir}, 32'd1);
    chk("rel_word_gecerli", {31'd0, word_gecerli}, 32'd0);
    @(negedge clk);
  endtask

  // Monitor: samples 2ns before each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rstn && word_gecerli) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h expected none", word_veri);
        end else begin
          e = exp_q[0];
          chk("word_veri", word_veri, e.w);
          chk("word_satir_son", {31'd0, word_satir_son}, {31'd0, e.s});
          chk("word_son", {31'd0, word_son}, {31'd0, e.l});
          if (word_hazir) begin
            void'(exp_q.pop_front());
            hs_cyc.push_back(cyc);
            if (e.s) satir_cnt++;
            if (e.l) begin
              son_cnt++;
              chk("frame_ctr_pre", {16'd0, frame_ctr}, exp_frames);
              exp_frames++;
            end
          end
        end
      end
    end
  end

  initial begin
    int st;
    rstn = 1'b0;
    dn_gecerli = 1'b0;
    dn_veri = '0;
    word_hazir = 1'b0;

    // Power-on reset
    repeat (2) @(negedge clk);
    chk("por_word_gecerli", {31'd0, word_gecerli}, 32'd0);
    chk("por_frame_ctr", {16'd0, frame_ctr}, 32'd0);
    rstn = 1'b1;
    #3;
    chk("por_dn_hazir", {31'd0, dn_hazir}, 32'd1);
    @(negedge clk);

    // Async reset with a word pending
    send_seq(8'hA1, 8'h01, 4, st);
    do_reset();

    // Pack order and one-cycle latency
    word_hazir = 1'b1;
    send_seq(8'h11, 8'h11, 4, st);
    #3;
    chk("lat_word_gecerli", {31'd0, word_gecerli}, 32'd1);
    chk("lat_word_veri", word_veri, 32'h44332211);
    @(negedge clk);
    #3;
    chk("drop_word_gecerli", {31'd0, word_gecerli}, 32'd0);
    @(negedge clk);

    // Backpressure: 4th pixel of next word stalls until writer ready
    word_hazir = 1'b0;
    send_seq(8'h50, 8'h01, 4, st);
    send_seq(8'h60, 8'h01, 3, st);
    chk("bp_no_early_stall", st, 0);
    fork
      begin
        repeat (3) @(negedge clk);
        word_hazir = 1'b1;
      end
    join_none
    send(8'h63, st);
    dn_gecerli = 1'b0;
    chk("bp_stall_cycles", st, 3);
    repeat (2) @(negedge clk);

    // Full rate across a frame boundary
    hs_cyc.delete();
    send_seq(8'h80, 8'h01, 8, st);
    repeat (2) @(negedge clk);
    chk("fr_stalls", st, 0);
    chk("fr_word_count", hs_cyc.size(), 2);
    if (hs_cyc.size() == 2)
      chk("fr_word_spacing", hs_cyc[1] - hs_cyc[0], 4);
    chk("fr_frame_ctr", {16'd0, frame_ctr}, 32'd1);

    // Frame tags from a clean start
    do_reset();
    satir_cnt = 0;
    son_cnt = 0;
    send_seq(8'hC0, 8'h01, 16, st);
    repeat (2) @(negedge clk);
    chk("tag_satir_count", satir_cnt, 2);
    chk("tag_son_count", son_cnt, 1);
    chk("tag_frame_ctr", {16'd0, frame_ctr}, 32'd1);

    // Second frame back-to-back, then reset mid third frame
    send_seq(8'hE0, 8'h01, 16, st);
    repeat (2) @(negedge clk);
    chk("f2_frame_ctr", {16'd0, frame_ctr}, 32'd2);
    send_seq(8'h30, 8'h01, 5, st);
    repeat (2) @(negedge clk);
    chk("f3_frame_ctr", {16'd0, frame_ctr}, 32'd2);
    do_reset();
    send_seq(8'h01, 8'h01, 4, st);
    #3;
    chk("post_rst_word", word_veri, 32'h04030201);
    chk("post_rst_satir", {31'd0, word_satir_son}, 32'd0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
